// File: rtl/systolic_tile_engine_pkg.sv
// Shared defaults, operand/result types and FSM state encoding for the
// systolic tile engine and its helpers.
package systolic_tile_engine_pkg;

   localparam int N_DEF      = 4;
   localparam int DW_DEF     = 16;
   localparam int ACC_W_DEF  = 40;
   localparam int TCNT_W_DEF = 16;

   typedef logic signed [DW_DEF-1:0]    operand_t;
   typedef logic signed [ACC_W_DEF-1:0] acc_t;

   typedef struct packed {
      logic [N_DEF*DW_DEF-1:0] data;
      logic                    last;
   } matrix_data_t;

   // Member names carry a prefix so they never collide with the FLUSH parameter.
   typedef enum logic [1:0] {
      ST_FEED  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } tile_state_e;

endpackage

// File: rtl/systolic_tile_engine_skew_line.sv
// Per-lane delay line: lane i is delayed by exactly i clock cycles, lane 0 is
// a straight pass-through. Used for both the A rows and the B columns.
module systolic_tile_engine_skew_line #(
   parameter int N = 4,
   parameter int W = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [N*W-1:0] d_i,
   output logic [N*W-1:0] q_o
);

   assign q_o[W-1:0] = d_i[W-1:0];

   genvar gi;
   generate
      for (gi = 1; gi < N; gi++) begin : g_lane
         logic [W-1:0] sr_q [gi];

         // Shift lane gi through its gi-deep register chain.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int s = 0; s < gi; s++) sr_q[s] <= '0;
            end else begin
               sr_q[0] <= d_i[gi*W +: W];
               for (int s = 1; s < gi; s++) sr_q[s] <= sr_q[s-1];
            end
         end

         assign q_o[gi*W +: W] = sr_q[gi-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_tile_engine.sv
// Output-stationary tile engine: skewed operand beats feed an N x N MAC grid,
// the grid is flushed with zeros, accumulators are snapshotted into a result
// buffer and the buffer is drained one row per handshake.
module systolic_tile_engine
   import systolic_tile_engine_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int DW     = DW_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int FLUSH  = 2*N+2,
   parameter int TCNT_W = TCNT_W_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic                in_last_i,
   input  logic [N*DW-1:0]     a_i,
   input  logic [N*DW-1:0]     b_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                out_last_o,
   output logic [N*ACC_W-1:0]  c_o,
   output logic [TCNT_W-1:0]   tile_cnt_o,
   output logic                ovf_o
);

   // Beats beyond 2^E can overflow the accumulator headroom.
   localparam int E  = ACC_W - 2*DW;
   localparam int KW = E + 1;
   localparam int FW = $clog2(FLUSH + 1);
   localparam int RW = $clog2(N);
   localparam logic [KW-1:0] K_LIM = KW'(1) << E;

   tile_state_e         state_q, state_d;
   logic [FW-1:0]       flush_q, flush_d;
   logic [KW-1:0]       k_q, k_d;
   logic [RW-1:0]       row_q, row_d;
   logic [TCNT_W-1:0]   tile_cnt_q, tile_cnt_d;
   logic                ovf_q, ovf_d;
   logic                capture;
   logic                accept;

   logic [N*DW-1:0]     a_feed, b_feed, a_sk, b_sk;

   logic signed [DW-1:0]    a_pass [N][N];
   logic signed [DW-1:0]    b_pass [N][N];
   logic signed [ACC_W-1:0] acc_w  [N][N];
   logic signed [ACC_W-1:0] buf_q  [N][N];

   assign accept = in_valid_i && (state_q == ST_FEED);

   // Idle cycles inject zeros so the grid keeps marching without accumulating.
   assign a_feed = accept ? a_i : '0;
   assign b_feed = accept ? b_i : '0;

   systolic_tile_engine_skew_line #(.N(N), .W(DW)) u_skew_a (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (a_feed), .q_o (a_sk)
   );

   systolic_tile_engine_skew_line #(.N(N), .W(DW)) u_skew_b (
      .clk_i (clk_i), .rst_i (rst_i), .d_i (b_feed), .q_o (b_sk)
   );

   // Next-state, counter and snapshot control for FEED -> FLUSH -> DRAIN.
   always_comb begin
      state_d    = state_q;
      flush_d    = flush_q;
      k_d        = k_q;
      row_d      = row_q;
      tile_cnt_d = tile_cnt_q;
      ovf_d      = ovf_q;
      capture    = 1'b0;
      case (state_q)
         ST_FEED: begin
            if (accept) begin
               if (k_q == K_LIM) ovf_d = 1'b1;
               else              k_d   = k_q + KW'(1);
               if (in_last_i) begin
                  state_d = ST_FLUSH;
                  flush_d = FW'(FLUSH - 1);
               end
            end
         end
         ST_FLUSH: begin
            if (flush_q == '0) begin
               capture = 1'b1;
               row_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               flush_d = flush_q - FW'(1);
            end
         end
         ST_DRAIN: begin
            if (out_ready_i) begin
               if (row_q == RW'(N - 1)) begin
                  state_d    = ST_FEED;
                  row_d      = '0;
                  k_d        = '0;
                  tile_cnt_d = tile_cnt_q + TCNT_W'(1);
               end else begin
                  row_d = row_q + RW'(1);
               end
            end
         end
         default: state_d = ST_FEED;
      endcase
   end

   // Control state registers; reset aborts whatever tile is in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_FEED;
         flush_q    <= '0;
         k_q        <= '0;
         row_q      <= '0;
         tile_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         flush_q    <= flush_d;
         k_q        <= k_d;
         row_q      <= row_d;
         tile_cnt_q <= tile_cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            logic signed [DW-1:0]    a_in, b_in, a_q, b_q;
            logic signed [ACC_W-1:0] acc_q, prod;

            if (gj == 0) begin : g_a_edge
               assign a_in = a_sk[gi*DW +: DW];
            end else begin : g_a_inner
               assign a_in = a_pass[gi][gj-1];
            end

            if (gi == 0) begin : g_b_edge
               assign b_in = b_sk[gj*DW +: DW];
            end else begin : g_b_inner
               assign b_in = b_pass[gi-1][gj];
            end

            // Sign-extend before multiplying so the product wraps at ACC_W.
            assign prod = ACC_W'(a_in) * ACC_W'(b_in);

            // PE: forward operands right/down and accumulate their product.
            always_ff @(posedge clk_i) begin
               if (rst_i) begin
                  a_q   <= '0;
                  b_q   <= '0;
                  acc_q <= '0;
               end else begin
                  a_q   <= a_in;
                  b_q   <= b_in;
                  acc_q <= capture ? '0 : acc_q + prod;
               end
            end

            assign a_pass[gi][gj] = a_q;
            assign b_pass[gi][gj] = b_q;
            assign acc_w[gi][gj]  = acc_q;
         end
      end
   endgenerate

   // Snapshot the whole grid when the flush completes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) buf_q[r][c] <= '0;
      end else if (capture) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) buf_q[r][c] <= acc_w[r][c];
      end
   end

   assign in_ready_o  = (state_q == ST_FEED);
   assign out_valid_o = (state_q == ST_DRAIN);
   assign out_last_o  = out_valid_o && (row_q == RW'(N - 1));
   assign tile_cnt_o  = tile_cnt_q;
   assign ovf_o       = ovf_q;

   generate
      for (gi = 0; gi < N; gi++) begin : g_out
         assign c_o[gi*ACC_W +: ACC_W] = out_valid_o ? buf_q[row_q][gi] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: a default-size instance for the
// functional scenarios and a narrow-accumulator instance for overflow/wrap.
module tb_systolic_tile_engine;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 40;
   localparam int FL = 2*N+2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance
   logic            in_valid, in_ready, in_last, out_valid, out_ready, out_last, ovf;
   logic [N*DW-1:0] a, b;
   logic [N*AW-1:0] c;
   logic [15:0]     tile_cnt;

   // narrow instance: DW=4, ACC_W=9, TCNT_W=2
   logic            o_in_valid, o_in_ready, o_in_last, o_out_valid, o_out_last, o_ovf;
   logic [15:0]     o_a, o_b;
   logic [35:0]     o_c;
   logic [1:0]      o_tile_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0]  beat_a [0:7];
   logic [63:0]  beat_b [0:7];
   logic [159:0] got_c [0:3];
   logic         got_last [0:3];
   logic         got_valid [0:3];

   systolic_tile_engine #(.N(N), .DW(DW), .ACC_W(AW), .FLUSH(FL), .TCNT_W(16)) u_dut (
      .clk_i (clk), .rst_i (rst),
      .in_valid_i (in_valid), .in_ready_o (in_ready), .in_last_i (in_last),
      .a_i (a), .b_i (b),
      .out_valid_o (out_valid), .out_ready_i (out_ready), .out_last_o (out_last),
      .c_o (c), .tile_cnt_o (tile_cnt), .ovf_o (ovf)
   );

   systolic_tile_engine #(.N(4), .DW(4), .ACC_W(9), .FLUSH(10), .TCNT_W(2)) u_ovf (
      .clk_i (clk), .rst_i (rst),
      .in_valid_i (o_in_valid), .in_ready_o (o_in_ready), .in_last_i (o_in_last),
      .a_i (o_a), .b_i (o_b),
      .out_valid_o (o_out_valid), .out_ready_i (1'b1), .out_last_o (o_out_last),
      .c_o (o_c), .tile_cnt_o (o_tile_cnt), .ovf_o (o_ovf)
   );

   function automatic logic [63:0] op4(input int v0, input int v1, input int v2, input int v3);
      logic [63:0] r;
      r[15:0]  = 16'(v0);
      r[31:16] = 16'(v1);
      r[47:32] = 16'(v2);
      r[63:48] = 16'(v3);
      return r;
   endfunction

   function automatic logic [159:0] row4(input longint v0, input longint v1, input longint v2, input longint v3);
      logic [159:0] r;
      r[39:0]    = 40'(v0);
      r[79:40]   = 40'(v1);
      r[119:80]  = 40'(v2);
      r[159:120] = 40'(v3);
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      o_in_valid = 1'b0; o_in_last = 1'b0; o_a = '0; o_b = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // A = identity, B = 1..16 row-major; beat k = column k of A, row k of B.
   task automatic set_identity_tile();
      for (int k = 0; k < 4; k++) begin
         beat_a[k] = op4(int'(k == 0), int'(k == 1), int'(k == 2), int'(k == 3));
         beat_b[k] = op4(4*k+1, 4*k+2, 4*k+3, 4*k+4);
      end
   endtask

   task automatic feed_beats(input int nk);
      for (int k = 0; k < nk; k++) begin
         in_valid = 1'b1; a = beat_a[k]; b = beat_b[k]; in_last = (k == nk-1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain_capture();
      for (int r = 0; r < 4; r++) begin
         got_valid[r] = out_valid; got_c[r] = c; got_last[r] = out_last;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; a = '1; b = '1; out_ready = 1'b1;
      o_in_valid = 1'b0; o_in_last = 1'b0; o_a = '0; o_b = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
      n_cmp++; if (c !== '0) begin n_err++; $display("FAIL reset_c: got %0h want 0", c); end
      n_cmp++; if (tile_cnt !== 16'd0) begin n_err++; $display("FAIL reset_tile_cnt: got %0d want 0", tile_cnt); end
      n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0;
      $display("test_reset done");
   endtask

   task automatic test_identity();
      int lat;
      do_reset();
      set_identity_tile();
      feed_beats(4);
      wait_valid(lat);
      n_cmp++; if (lat !== FL) begin n_err++; $display("FAIL ident_latency: got %0d want %0d", lat, FL); end
      drain_capture();
      for (int r = 0; r < 4; r++) begin
         n_cmp++; if (got_valid[r] !== 1'b1) begin n_err++; $display("FAIL ident_valid row%0d: got %0b want 1", r, got_valid[r]); end
         n_cmp++; if (got_c[r] !== row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)) begin n_err++; $display("FAIL ident_row%0d: got %0h want %0h", r, got_c[r], row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)); end
         n_cmp++; if (got_last[r] !== (r == 3)) begin n_err++; $display("FAIL ident_last row%0d: got %0b want %0b", r, got_last[r], (r == 3)); end
      end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ident_valid_after: got %0b want 0", out_valid); end
      n_cmp++; if (tile_cnt !== 16'd1) begin n_err++; $display("FAIL ident_tile_cnt: got %0d want 1", tile_cnt); end
      $display("test_identity done");
   endtask

   task automatic test_backpressure();
      int lat;
      do_reset();
      set_identity_tile();
      feed_beats(4);
      wait_valid(lat);
      for (int r = 0; r < 2; r++) begin
         n_cmp++; if (c !== row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)) begin n_err++; $display("FAIL bp_row%0d: got %0h want %0h", r, c, row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)); end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         n_cmp++; if (c !== row4(9, 10, 11, 12)) begin n_err++; $display("FAIL bp_stall%0d_c: got %0h want %0h", s, c, row4(9, 10, 11, 12)); end
         n_cmp++; if (out_valid !== 1'b1 || out_last !== 1'b0) begin n_err++; $display("FAIL bp_stall%0d_flags: got valid=%0b last=%0b want valid=1 last=0", s, out_valid, out_last); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      n_cmp++; if (c !== row4(9, 10, 11, 12)) begin n_err++; $display("FAIL bp_row2: got %0h want %0h", c, row4(9, 10, 11, 12)); end
      @(posedge clk); #1;
      n_cmp++; if (c !== row4(13, 14, 15, 16) || out_last !== 1'b1) begin n_err++; $display("FAIL bp_row3: got %0h last=%0b want %0h last=1", c, out_last, row4(13, 14, 15, 16)); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || tile_cnt !== 16'd1) begin n_err++; $display("FAIL bp_end: got valid=%0b cnt=%0d want valid=0 cnt=1", out_valid, tile_cnt); end
      $display("test_backpressure done");
   endtask

   task automatic test_single_beat();
      int lat;
      int av[4] = '{2, -3, 4, -5};
      do_reset();
      in_last = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      in_last = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL k1_lone_last: got ready=%0b valid=%0b want ready=1 valid=0", in_ready, out_valid); end
      beat_a[0] = op4(2, -3, 4, -5);
      beat_b[0] = op4(7, 7, 7, 7);
      feed_beats(1);
      wait_valid(lat);
      n_cmp++; if (lat + 1 !== FL + 1) begin n_err++; $display("FAIL k1_latency: got %0d want %0d cycles", lat + 1, FL + 1); end
      drain_capture();
      for (int r = 0; r < 4; r++) begin
         n_cmp++; if (got_c[r] !== row4(av[r]*7, av[r]*7, av[r]*7, av[r]*7)) begin n_err++; $display("FAIL k1_row%0d: got %0h want %0h", r, got_c[r], row4(av[r]*7, av[r]*7, av[r]*7, av[r]*7)); end
      end
      n_cmp++; if (tile_cnt !== 16'd1) begin n_err++; $display("FAIL k1_tile_cnt: got %0d want 1", tile_cnt); end
      $display("test_single_beat done");
   endtask

   task automatic test_back_to_back();
      int lat;
      do_reset();
      set_identity_tile();
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; a = beat_a[k]; b = beat_b[k]; in_last = (k == 3);
         @(posedge clk); #1;
      end
      // junk beat marked last stays offered while the engine is busy
      a = op4(99, 99, 99, 99); b = op4(99, 99, 99, 99); in_last = 1'b1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_flush: got %0b want 0", in_ready); end
      wait_valid(lat);
      n_cmp++; if (lat !== FL) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, FL); end
      for (int r = 0; r < 4; r++) begin
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drain row%0d: got %0b want 0", r, in_ready); end
         n_cmp++; if (c !== row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)) begin n_err++; $display("FAIL b2b_t1_row%0d: got %0h want %0h", r, c, row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)); end
         @(posedge clk); #1;
      end
      n_cmp++; if (tile_cnt !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_mid: got cnt=%0d valid=%0b ready=%0b want cnt=1 valid=0 ready=1", tile_cnt, out_valid, in_ready); end
      a = op4(1, 2, 3, 4); b = op4(1, 1, 1, 1); in_last = 1'b0;
      @(posedge clk); #1;
      a = op4(-1, -1, -1, -1); b = op4(0, 0, 0, 10); in_last = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0;
      wait_valid(lat);
      drain_capture();
      for (int r = 0; r < 4; r++) begin
         n_cmp++; if (got_c[r] !== row4(r+1, r+1, r+1, r-9)) begin n_err++; $display("FAIL b2b_t2_row%0d: got %0h want %0h", r, got_c[r], row4(r+1, r+1, r+1, r-9)); end
      end
      n_cmp++; if (tile_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_tile_cnt: got %0d want 2", tile_cnt); end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_abort();
      int lat;
      int av[4] = '{2, -3, 4, -5};
      do_reset();
      set_identity_tile();
      feed_beats(4);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin n_err++; $display("FAIL abort_flush_flags: got ready=%0b valid=%0b last=%0b want 1/0/0", in_ready, out_valid, out_last); end
      n_cmp++; if (c !== '0 || tile_cnt !== 16'd0 || ovf !== 1'b0) begin n_err++; $display("FAIL abort_flush_out: got c=%0h cnt=%0d ovf=%0b want 0/0/0", c, tile_cnt, ovf); end
      rst = 1'b0;
      beat_a[0] = op4(2, -3, 4, -5);
      beat_b[0] = op4(7, 7, 7, 7);
      feed_beats(1);
      wait_valid(lat);
      n_cmp++; if (lat !== FL) begin n_err++; $display("FAIL abort_recover_latency: got %0d want %0d", lat, FL); end
      drain_capture();
      for (int r = 0; r < 4; r++) begin
         n_cmp++; if (got_c[r] !== row4(av[r]*7, av[r]*7, av[r]*7, av[r]*7)) begin n_err++; $display("FAIL abort_recover_row%0d: got %0h want %0h", r, got_c[r], row4(av[r]*7, av[r]*7, av[r]*7, av[r]*7)); end
      end
      n_cmp++; if (tile_cnt !== 16'd1) begin n_err++; $display("FAIL abort_recover_cnt: got %0d want 1", tile_cnt); end
      // abort during drain, with out_ready high on the reset edge
      set_identity_tile();
      feed_beats(4);
      wait_valid(lat);
      @(posedge clk); #1;
      n_cmp++; if (c !== row4(5, 6, 7, 8)) begin n_err++; $display("FAIL abort_drain_row1: got %0h want %0h", c, row4(5, 6, 7, 8)); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || c !== '0 || tile_cnt !== 16'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL abort_drain: got valid=%0b c=%0h cnt=%0d ready=%0b want 0/0/0/1", out_valid, c, tile_cnt, in_ready); end
      rst = 1'b0;
      feed_beats(4);
      wait_valid(lat);
      drain_capture();
      for (int r = 0; r < 4; r++) begin
         n_cmp++; if (got_c[r] !== row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)) begin n_err++; $display("FAIL abort_final_row%0d: got %0h want %0h", r, got_c[r], row4(4*r+1, 4*r+2, 4*r+3, 4*r+4)); end
      end
      n_cmp++; if (tile_cnt !== 16'd1) begin n_err++; $display("FAIL abort_final_cnt: got %0d want 1", tile_cnt); end
      $display("test_reset_abort done");
   endtask

   task automatic test_overflow_wrap();
      int wt;
      do_reset();
      // three beats of max-negative operands: each product is 64, sum 192
      o_a = 16'h8888; o_b = 16'h8888; o_in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         o_in_last = (k == 2);
         @(posedge clk); #1;
         if (k == 1) begin
            n_cmp++; if (o_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %0b want 0", o_ovf); end
         end
      end
      o_in_valid = 1'b0; o_in_last = 1'b0; o_a = '0; o_b = '0;
      n_cmp++; if (o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b want 1", o_ovf); end
      wt = 0;
      while (!o_out_valid && wt < 60) begin @(posedge clk); #1; wt++; end
      for (int r = 0; r < 4; r++) begin
         n_cmp++; if (o_c !== {4{9'd192}} || o_out_last !== (r == 3)) begin n_err++; $display("FAIL ovf_row%0d: got %0h last=%0b want %0h last=%0b", r, o_c, o_out_last, {4{9'd192}}, (r == 3)); end
         @(posedge clk); #1;
      end
      n_cmp++; if (o_tile_cnt !== 2'd1 || o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_tile1: got cnt=%0d ovf=%0b want cnt=1 ovf=1", o_tile_cnt, o_ovf); end
      // further unit tiles: ovf stays set, 2-bit counter wraps 3 -> 0
      for (int t = 2; t <= 4; t++) begin
         o_a = 16'h1111; o_b = 16'h1111; o_in_valid = 1'b1; o_in_last = 1'b1;
         @(posedge clk); #1;
         o_in_valid = 1'b0; o_in_last = 1'b0; o_a = '0; o_b = '0;
         wt = 0;
         while (!o_out_valid && wt < 60) begin @(posedge clk); #1; wt++; end
         n_cmp++; if (o_c !== {4{9'd1}}) begin n_err++; $display("FAIL ovf_unit_tile%0d: got %0h want %0h", t, o_c, {4{9'd1}}); end
         repeat (4) begin @(posedge clk); #1; end
         n_cmp++; if (o_tile_cnt !== 2'(t % 4) || o_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_wrap%0d: got cnt=%0d ovf=%0b want cnt=%0d ovf=1", t, o_tile_cnt, o_ovf, t % 4); end
      end
      $display("test_overflow_wrap done");
   endtask

   initial begin
      test_reset();
      test_identity();
      test_backpressure();
      test_single_beat();
      test_back_to_back();
      test_reset_abort();
      test_overflow_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
